// File: rtl/polyunit_pkg.sv
// Shared encodings and helpers for the Kyber poly unit sequencer.
package polyunit_pkg;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_NTT  = 2'b01;
  localparam logic [1:0] MODE_INTT = 2'b10;
  localparam logic [1:0] MODE_DUMP = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_XFORM = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DUMP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/polyunit_agen.sv
// Pair/pass counters producing butterfly operand addresses and twiddle indices.
// A transform is AWID word stages plus one in-word pass, walked forward or reversed.
module polyunit_agen
  import polyunit_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AWID  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            issue_i,
  input  logic            nextPass_i,
  input  logic            inv_i,
  output logic [AWID-1:0] addrA_o,
  output logic [AWID-1:0] addrB_o,
  output logic [AWID:0]   tw_o,
  output logic            intra_o,
  output logic            lastIssue_o,
  output logic            lastPass_o
);

  localparam int PASS_W = clog2(AWID + 1);
  localparam logic [PASS_W-1:0] LAST_PASS      = PASS_W'(AWID);
  localparam logic [AWID-1:0]   LAST_WORD_PAIR = AWID'(DEPTH / 2 - 1);
  localparam logic [AWID-1:0]   LAST_INTRA     = AWID'(DEPTH - 1);
  localparam logic [AWID:0]     TW_ONE         = {{AWID{1'b0}}, 1'b1};

  logic [AWID-1:0]   pair_q, pair_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] stage, shamt, shamtUp;
  logic [AWID-1:0]   grp, halfBit, lowMask, wordA;

  // Word stage s pairs words half=2^(AWID-1-s) apart inside groups of 2*half.
  always_comb begin
    intra_o = inv_i ? (pass_q == '0) : (pass_q == LAST_PASS);
    stage   = inv_i ? (LAST_PASS - pass_q) : pass_q;
    shamt   = LAST_PASS - stage - PASS_W'(1);
    shamtUp = shamt + PASS_W'(1);
    halfBit = AWID'(1) << shamt;
    lowMask = halfBit - AWID'(1);
    grp     = pair_q >> shamt;
    wordA   = (grp << shamtUp) | (pair_q & lowMask);
    if (intra_o) begin
      addrA_o     = pair_q;
      addrB_o     = pair_q;
      tw_o        = {1'b1, pair_q};
      lastIssue_o = (pair_q == LAST_INTRA);
    end else begin
      addrA_o     = wordA;
      addrB_o     = wordA | halfBit;
      tw_o        = (TW_ONE << stage) + {1'b0, grp};
      lastIssue_o = (pair_q == LAST_WORD_PAIR);
    end
    lastPass_o = (pass_q == LAST_PASS);
  end

  always_comb begin
    pair_d = pair_q;
    pass_d = pass_q;
    if (issue_i) pair_d = lastIssue_o ? '0 : pair_q + AWID'(1);
    if (nextPass_i && !lastPass_o) pass_d = pass_q + PASS_W'(1);
    if (clear_i) begin
      pair_d = '0;
      pass_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q <= '0;
      pass_q <= '0;
    end else begin
      pair_q <= pair_d;
      pass_q <= pass_d;
    end
  end

endmodule

// File: rtl/polyunit_seq.sv
// Sequencer and coefficient RAM arbiter for the Kyber poly unit:
// streamed load, forward/inverse transform issue, and streamed dump.
module polyunit_seq
  import polyunit_pkg::*;
#(
  parameter int WID    = 12,
  parameter int LANES  = 4,
  parameter int DEPTH  = 64,
  parameter int AWID   = 6,
  parameter int BF_LAT = 4,
  parameter int DWID   = WID * LANES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic            run,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DWID-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DWID-1:0] out_data,
  output logic [AWID-1:0] ram_ra,
  output logic            ram_re,
  input  logic [DWID-1:0] ram_rdata,
  output logic [AWID-1:0] ram_wa,
  output logic            ram_we,
  output logic [DWID-1:0] ram_wdata,
  output logic            bf_valid,
  output logic [AWID-1:0] bf_addr_a,
  output logic [AWID-1:0] bf_addr_b,
  output logic [AWID:0]   bf_tw,
  output logic            bf_intra,
  output logic            bf_inv,
  input  logic            wb_we,
  input  logic [AWID-1:0] wb_addr,
  input  logic [DWID-1:0] wb_data
);

  localparam logic [AWID-1:0] LAST_WORD = AWID'(DEPTH - 1);
  localparam logic [3:0]      DRAIN_END = 4'(BF_LAT - 1);

  logic [2:0]      state_q, state_d;
  logic [1:0]      mode_q;
  logic [AWID:0]   cnt_q;
  logic [AWID-1:0] popCnt_q;
  logic [3:0]      drainCnt_q;
  logic [DWID-1:0] fifoMem_q [2];
  logic            wrPtr_q, rdPtr_q;
  logic [1:0]      occ_q;
  logic            inflight_q;

  logic            loadFire, pop, xformPhase, drainEnd;
  logic [2:0]      credit, limit;
  logic            agIntra, agLastIssue, agLastPass;

  polyunit_agen #(
    .DEPTH(DEPTH),
    .AWID (AWID)
  ) u_agen (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == ST_IDLE),
    .issue_i    (bf_valid),
    .nextPass_i (drainEnd),
    .inv_i      (mode_q == MODE_INTT),
    .addrA_o    (bf_addr_a),
    .addrB_o    (bf_addr_b),
    .tw_o       (bf_tw),
    .intra_o    (agIntra),
    .lastIssue_o(agLastIssue),
    .lastPass_o (agLastPass)
  );

  // A pop in the same cycle frees a FIFO slot, which keeps the dump at full rate.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    in_ready   = (state_q == ST_LOAD);
    loadFire   = in_ready && in_valid;
    xformPhase = (state_q == ST_XFORM) || (state_q == ST_DRAIN);
    drainEnd   = (state_q == ST_DRAIN) && (drainCnt_q == DRAIN_END);
    bf_valid   = (state_q == ST_XFORM);
    bf_intra   = bf_valid && agIntra;
    bf_inv     = xformPhase && (mode_q == MODE_INTT);
    out_valid  = (state_q == ST_DUMP) && (occ_q != 2'd0);
    out_data   = fifoMem_q[rdPtr_q];
    pop        = out_valid && out_ready;
    credit     = {1'b0, occ_q} + {2'b00, inflight_q};
    limit      = 3'd2 + {2'b00, pop};
    ram_re     = (state_q == ST_DUMP) && !cnt_q[AWID] && (credit < limit);
    ram_ra     = cnt_q[AWID-1:0];
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_wa    = cnt_q[AWID-1:0];
    ram_wdata = in_data;
    if (state_q == ST_LOAD) begin
      ram_we = in_valid;
    end else if (xformPhase) begin
      ram_we    = wb_we;
      ram_wa    = wb_addr;
      ram_wdata = wb_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          case (mode)
            MODE_LOAD: state_d = ST_LOAD;
            MODE_DUMP: state_d = ST_DUMP;
            default:   state_d = ST_XFORM;
          endcase
        end
      end
      ST_LOAD:  if (loadFire && (cnt_q[AWID-1:0] == LAST_WORD)) state_d = ST_DONE;
      ST_XFORM: if (agLastIssue) state_d = ST_DRAIN;
      ST_DRAIN: if (drainEnd) state_d = agLastPass ? ST_DONE : ST_XFORM;
      ST_DUMP:  if (pop && (popCnt_q == LAST_WORD)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_LOAD;
      cnt_q      <= '0;
      popCnt_q   <= '0;
      drainCnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if ((state_q == ST_IDLE) && run) mode_q <= mode;
      drainCnt_q <= ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) ? drainCnt_q + 4'd1 : 4'd0;
      inflight_q <= ram_re;
      if (state_q == ST_IDLE) begin
        cnt_q    <= '0;
        popCnt_q <= '0;
      end else begin
        if ((loadFire || ram_re) && !cnt_q[AWID]) cnt_q <= cnt_q + 1'b1;
        if (pop && (popCnt_q != LAST_WORD)) popCnt_q <= popCnt_q + 1'b1;
      end
    end
  end

  // Read data returns one cycle after the read strobe and lands in the FIFO tail.
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE)) begin
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifoMem_q[wrPtr_q] <= ram_rdata;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_polyunit_seq.sv
// Directed bench for polyunit_seq: load, dump, NTT/INTT issue order and timing, abort.
module tb_polyunit_seq;
  import polyunit_pkg::*;

  localparam int WID = 12, LANES = 4, DEPTH = 64, AWID = 6, BF_LAT = 4;
  localparam int DWID = WID * LANES;

  logic            clk = 1'b0;
  logic            rst, run, in_valid, out_ready, wb_we;
  logic [1:0]      mode;
  logic [DWID-1:0] in_data, wb_data, out_data, ram_rdata, ram_wdata;
  logic [AWID-1:0] wb_addr, ram_ra, ram_wa, bf_addr_a, bf_addr_b;
  logic [AWID:0]   bf_tw;
  logic            busy, done, in_ready, out_valid, ram_re, ram_we;
  logic            bf_valid, bf_intra, bf_inv;

  typedef struct { int cyc; int a; int b; int tw; bit intra; bit inv; } issue_t;
  typedef struct { int wa; logic [DWID-1:0] data; } wr_t;
  typedef struct { bit inv; int idx; int a; int b; int tw; bit intra; } vec_t;

  issue_t issueLog[$], nttLog[$], inttLog[$], expQ[$];
  wr_t    wrLog[$];
  vec_t   vecs[15];
  logic [DWID-1:0] ramMem [DEPTH];
  int cycCnt = 0, doneCount = 0, total = 0, bad = 0;

  polyunit_seq #(
    .WID(WID), .LANES(LANES), .DEPTH(DEPTH), .AWID(AWID), .BF_LAT(BF_LAT), .DWID(DWID)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .run(run), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .bf_tw(bf_tw),
    .bf_intra(bf_intra), .bf_inv(bf_inv),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycCnt <= cycCnt + 1;
    if (ram_we) ramMem[ram_wa] <= ram_wdata;
    if (ram_re) ram_rdata <= ramMem[ram_ra];
  end

  // Observe DUT activity mid-cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    issue_t it;
    wr_t    wr;
    if (bf_valid) begin
      it.cyc = cycCnt; it.a = int'(bf_addr_a); it.b = int'(bf_addr_b);
      it.tw = int'(bf_tw); it.intra = bf_intra; it.inv = bf_inv;
      issueLog.push_back(it);
    end
    if (ram_we) begin
      wr.wa = int'(ram_wa); wr.data = ram_wdata;
      wrLog.push_back(wr);
    end
    if (done) doneCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DWID-1:0] wordOf(input int i);
    logic [DWID-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*WID +: WID] = WID'(i * LANES + l);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m);
    mode = m;
    run  = 1'b1;
    @(posedge clk); #1;
    run  = 1'b0;
  endtask

  task automatic loadWords();
    int i = 0, c = 0, errs = 0, d0, w0;
    bit fired;
    d0 = doneCount;
    w0 = wrLog.size();
    applyStimulus(MODE_LOAD);
    checkOutput("loadBusy", busy, 1);
    while (i < DEPTH && c < 400) begin
      in_valid = (c % 3 != 2);
      in_data  = wordOf(i);
      c++;
      #1;
      fired = in_valid && in_ready;
      @(posedge clk); #1;
      if (fired) i++;
    end
    in_valid = 1'b0;
    checkOutput("loadWordsSent", i, DEPTH);
    checkOutput("loadDonePulse", {done, in_ready}, 2'b10);
    @(posedge clk); #1;
    checkOutput("loadIdleAfter", {busy, done}, 2'b00);
    checkOutput("loadDoneCount", doneCount - d0, 1);
    checkOutput("loadWrCount", wrLog.size() - w0, DEPTH);
    for (int k = 0; k < DEPTH && (w0 + k) < wrLog.size(); k++) begin
      if (wrLog[w0+k].wa != k || wrLog[w0+k].data !== wordOf(k)) errs++;
    end
    checkOutput("loadWrContents", errs, 0);
  endtask

  task automatic runDump(input bit inject);
    logic readyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DWID-1:0] held;
    int got = 0, errs = 0, stallErrs = 0, d0, w0, budget;
    bit stalled = 0;
    d0 = doneCount;
    w0 = wrLog.size();
    held = '0;
    applyStimulus(MODE_DUMP);
    for (budget = 0; budget < 600 && got < DEPTH; budget++) begin
      out_ready = readyPat[budget % 4];
      if (inject && budget == 10) begin
        run = 1'b1; mode = MODE_NTT; wb_we = 1'b1; wb_addr = 6'd3; wb_data = wordOf(200);
      end else begin
        run = 1'b0; wb_we = 1'b0;
      end
      #1;
      if (inject && budget == 10)
        checkOutput("busyRunIgnored", {ram_we, bf_valid, in_ready, busy}, 4'b0001);
      if (stalled && (!out_valid || out_data !== held)) stallErrs++;
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        if (out_data !== wordOf(got)) errs++;
        got++;
      end
      @(posedge clk); #1;
    end
    run = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
    checkOutput("dumpWordCount", got, DEPTH);
    checkOutput("dumpOrder", errs, 0);
    checkOutput("dumpStallHold", stallErrs, 0);
    checkOutput("dumpDonePulse", done, 1);
    @(posedge clk); #1;
    checkOutput("dumpIdleAfter", busy, 0);
    checkOutput("dumpDoneCount", doneCount - d0, 1);
    checkOutput("dumpNoWrites", wrLog.size() - w0, 0);
  endtask

  task automatic runXform(input logic [1:0] m, input int abortAt, input bit wbProbe,
                          output int lat, output int startCyc);
    int cur;
    lat = 0;
    issueLog.delete();
    applyStimulus(m);
    startCyc = cycCnt;
    for (int budget = 0; budget < 400; budget++) begin
      cur = cycCnt - startCyc + 1;
      if (abortAt > 0 && cur == abortAt) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lat = -1;
        return;
      end
      if (wbProbe && cur == 34) begin
        wb_we = 1'b1; wb_addr = 6'd7; wb_data = wordOf(99);
        #1;
        checkOutput("drainWbPass", {ram_we, ram_wa, ram_wdata}, {1'b1, 6'd7, wordOf(99)});
      end else begin
        wb_we = 1'b0;
      end
      if (done) begin
        lat = cur;
        break;
      end
      @(posedge clk); #1;
    end
    wb_we = 1'b0;
  endtask

  // Expected issue stream built group by group rather than from the pair formula.
  task automatic buildExpect(input bit inv);
    int off, j, half, s;
    issue_t e;
    expQ.delete();
    off = 0;
    for (int k = 0; k <= AWID; k++) begin
      if ((inv && k == 0) || (!inv && k == AWID)) begin
        for (int w = 0; w < DEPTH; w++) begin
          e.cyc = off + w; e.a = w; e.b = w; e.tw = DEPTH + w; e.intra = 1'b1; e.inv = inv;
          expQ.push_back(e);
        end
        off += DEPTH + BF_LAT;
      end else begin
        s = inv ? AWID - k : k;
        half = DEPTH >> (s + 1);
        j = 0;
        for (int g = 0; g < (1 << s); g++) begin
          for (int t = 0; t < half; t++) begin
            e.cyc = off + j; e.a = g * 2 * half + t; e.b = e.a + half;
            e.tw = (1 << s) + g; e.intra = 1'b0; e.inv = inv;
            expQ.push_back(e);
            j++;
          end
        end
        off += DEPTH / 2 + BF_LAT;
      end
    end
  endtask

  task automatic compareIssues(input bit inv, input int start, input string tag);
    issue_t got[$];
    int errs = 0, first = -1, n;
    if (inv) got = inttLog;
    else got = nttLog;
    checkOutput({tag, "IssueCount"}, got.size(), expQ.size());
    n = (got.size() < expQ.size()) ? got.size() : expQ.size();
    for (int k = 0; k < n; k++) begin
      if (got[k].cyc - start != expQ[k].cyc || got[k].a != expQ[k].a || got[k].b != expQ[k].b ||
          got[k].tw != expQ[k].tw || got[k].intra != expQ[k].intra || got[k].inv != expQ[k].inv) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    checkOutput({tag, "IssueSeq"}, errs, 0);
    if (first >= 0)
      $display("[TB]   first diff at issue %0d: got cyc=%0d a=%0d b=%0d tw=%0d, want cyc=%0d a=%0d b=%0d tw=%0d",
               first, got[first].cyc - start, got[first].a, got[first].b, got[first].tw,
               expQ[first].cyc, expQ[first].a, expQ[first].b, expQ[first].tw);
  endtask

  initial begin
    int lat, start, d0;
    issue_t sel;

    vecs[0]  = '{0,   0,  0, 32,   1, 0};
    vecs[1]  = '{0,   1,  1, 33,   1, 0};
    vecs[2]  = '{0,  32,  0, 16,   2, 0};
    vecs[3]  = '{0,  33,  1, 17,   2, 0};
    vecs[4]  = '{0,  48, 32, 48,   3, 0};
    vecs[5]  = '{0, 191, 62, 63,  63, 0};
    vecs[6]  = '{0, 192,  0,  0,  64, 1};
    vecs[7]  = '{0, 255, 63, 63, 127, 1};
    vecs[8]  = '{1,   0,  0,  0,  64, 1};
    vecs[9]  = '{1,  63, 63, 63, 127, 1};
    vecs[10] = '{1,  64,  0,  1,  32, 0};
    vecs[11] = '{1,  65,  2,  3,  33, 0};
    vecs[12] = '{1, 192,  0, 16,   2, 0};
    vecs[13] = '{1, 224,  0, 32,   1, 0};
    vecs[14] = '{1, 255, 31, 63,   1, 0};

    rst = 1'b1; run = 1'b0; mode = MODE_LOAD; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOuts", {busy, done, in_ready, out_valid, ram_re, ram_we, bf_valid, bf_intra, bf_inv}, 9'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    wb_we = 1'b1; wb_addr = 6'd9; wb_data = wordOf(77);
    #1;
    checkOutput("idleWbBlocked", ram_we, 0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    checkOutput("idleStaysIdle", busy, 0);
    checkOutput("idleNoWrite", wrLog.size(), 0);

    loadWords();
    runDump(1'b1);

    runXform(MODE_NTT, 0, 1'b1, lat, start);
    nttLog = issueLog;
    checkOutput("nttLatency", lat, 285);
    @(posedge clk); #1;
    checkOutput("nttIdleAfter", {busy, done}, 2'b00);
    buildExpect(1'b0);
    compareIssues(1'b0, start, "ntt");

    runXform(MODE_INTT, 0, 1'b0, lat, start);
    inttLog = issueLog;
    checkOutput("inttLatency", lat, 285);
    @(posedge clk); #1;
    checkOutput("inttIdleAfter", {busy, bf_inv}, 2'b00);
    buildExpect(1'b1);
    compareIssues(1'b1, start, "intt");

    for (int v = 0; v < 15; v++) begin
      if (vecs[v].inv) sel = (vecs[v].idx < inttLog.size()) ? inttLog[vecs[v].idx] : '{-1, -1, -1, -1, 0, 0};
      else sel = (vecs[v].idx < nttLog.size()) ? nttLog[vecs[v].idx] : '{-1, -1, -1, -1, 0, 0};
      checkOutput($sformatf("vec%0d_%s_issue%0d", v, vecs[v].inv ? "intt" : "ntt", vecs[v].idx),
                  {8'(sel.a), 8'(sel.b), 8'(sel.tw), sel.intra},
                  {8'(vecs[v].a), 8'(vecs[v].b), 8'(vecs[v].tw), vecs[v].intra});
    end

    d0 = doneCount;
    runXform(MODE_NTT, 100, 1'b0, lat, start);
    checkOutput("abortReached", lat, -1);
    checkOutput("abortBusyLow", {busy, bf_valid}, 2'b00);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("abortNoDone", doneCount - d0, 0);
    checkOutput("abortStillIdle", busy, 0);

    runXform(MODE_NTT, 0, 1'b0, lat, start);
    nttLog = issueLog;
    checkOutput("nttRerunLatency", lat, 285);
    buildExpect(1'b0);
    compareIssues(1'b0, start, "nttRerun");
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polyunit_seq.md
Name: polyunit_seq

Overview:
Parametrised sequencer and RAM arbiter for the Kyber poly unit. It owns the packed coefficient RAM ports and runs four operations:
- LOAD: streamed coefficient load.
- NTT: forward transform, issuing butterfly operand pairs and twiddle indices.
- INTT: inverse transform, same issue scheme in reverse stage order.
- DUMP: streamed coefficient readout.

The butterfly datapath and twiddle ROM are external. Write-back from the butterfly datapath is routed through this block.

Parameters:
- WID, 12, coefficient width.
- LANES, 4, coefficients per RAM word (power of 2).
- DEPTH, 64, RAM words (power of 2, ≥4).
- AWID, 6, log2(DEPTH).
- BF_LAT, 4, butterfly issue-to-writeback latency in cycles (1..15).
- DWID, WID*LANES, RAM word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mode  in  2  00 LOAD, 01 NTT, 10 INTT, 11 DUMP
- run  in  1  start request; sampled only in IDLE
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on completion
- in_valid  in  1  LOAD data valid
- in_ready  out  1  LOAD data accepted
- in_data  in  DWID  LOAD word
- out_valid  out  1  DUMP data valid
- out_ready  in  1  DUMP consumer ready
- out_data  out  DWID  DUMP word
- ram_ra  out  AWID  RAM read address
- ram_re  out  1  RAM read enable; read data valid next cycle
- ram_rdata  in  DWID  RAM read data
- ram_wa  out  AWID  RAM write address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DWID  RAM write data
- bf_valid  out  1  butterfly issue strobe
- bf_addr_a  out  AWID  first operand word address
- bf_addr_b  out  AWID  second operand word address (equals bf_addr_a when bf_intra)
- bf_tw  out  AWID+1  twiddle ROM index
- bf_intra  out  1  issue is an in-word (lane) stage pass
- bf_inv  out  1  1 during INTT
- wb_we  in  1  butterfly write-back enable
- wb_addr  in  AWID  write-back address
- wb_data  in  DWID  write-back data

Behaviour:
- Reset: state IDLE; all counters 0. busy, done, in_ready, out_valid, ram_re, ram_we, bf_valid, bf_intra and bf_inv are 0. Output buffer is emptied.
- States: IDLE, LOAD, XFORM, DRAIN, DUMP, DONE.
- run in IDLE selects the next state from mode: LOAD, XFORM (NTT/INTT) or DUMP. run outside IDLE is ignored. mode is latched at start.
- DONE lasts exactly 1 cycle: done=1, then IDLE.
- LOAD:
  - in_ready=1; each in_valid&in_ready writes in_data to address cnt (ram_we same cycle, combinational passthrough), then cnt++.
  - After word DEPTH-1 is written, go to DONE; in_ready=0 in DONE.
- XFORM, stage loop:
  - Word stages s=0..AWID-1, half=DEPTH>>(s+1). Each stage issues DEPTH/2 pairs p, one per cycle: addr_a = ((p>>(AWID-1-s))<<(AWID-s)) | (p & (half-1)); addr_b = addr_a+half; bf_tw = (1<<s) + (p>>(AWID-1-s)).
  - Intra pass: DEPTH issues, addr_a=addr_b=word, bf_intra=1, bf_tw = DEPTH+word, truncated to AWID+1 bits.
  - NTT order: word stages s ascending, then intra pass.
  - INTT order: intra pass first, then word stages s descending. bf_inv=1 throughout.
- After each stage or pass, go to DRAIN for exactly BF_LAT cycles with no issue (RAW hazard guard), then start the next stage. After the final DRAIN, go to DONE.
- NTT/INTT cycle count, run to done (DEFAULTs): AWID*(DEPTH/2+BF_LAT)+(DEPTH+BF_LAT)+1 = 285.
- Write port mux:
  - In XFORM/DRAIN, ram_w* = wb_* (pure passthrough).
  - In other states, wb_we is ignored.
  - LOAD drives ram_w* itself.
- DUMP:
  - 2-entry output FIFO. A read of address cnt is issued only when (occupancy + inflight) < 2.
  - rdata is pushed into the FIFO the cycle after the read.
  - out_valid = FIFO non-empty; pop on out_valid&out_ready. out_data is held stable while out_valid&!out_ready.
  - Go to DONE after word DEPTH-1 has been popped.
  - Full throughput when out_ready is held at 1: one word per cycle after a 1-cycle startup latency.
- Counter wrap: counters saturate at their terminal count; no address wrap beyond DEPTH-1.
- rst mid-operation aborts immediately to IDLE; no done pulse; FIFO is flushed.

Decomposition:
- Package polyunit_pkg holds:
  - mode encodings MODE_LOAD/NTT/INTT/DUMP
  - state encodings
  - function clog2
- Sub-module polyunit_agen: stage/pair counters to addr_a/addr_b/tw, with inverse-order control. Pure counter logic, reused by a future Dilithium variant.

Test Plan:
- LOAD, DEPTH=64: stream words 0..63 with in_valid gaps every 3rd cycle. Expect 64 ram_we pulses with wa=0..63 and matching data; done pulse after the last write; busy low the following cycle.
- NTT, defaults: expect done exactly 285 cycles after run. First issue: a=0, b=32, tw=1. Stage-1 first issue: a=0, b=16, tw=2. Last word-stage issue: a=62, b=63, tw=63. Intra issues tw=64..127 with bf_intra=1.
- INTT: expect the first 64 issues intra with bf_inv=1, then word stages s=5..0. Last issue a=31, b=63, tw=1. Total 285 cycles.
- DUMP with out_ready toggling 1,0,0,1 after a LOAD of known data: expect out_data sequence 0..63 in order, no duplicates or drops, and out_data stable while stalled.
- run asserted while busy, plus an out-of-XFORM wb_we pulse: expect no state change and no ram_we.
- rst asserted mid-NTT at cycle 100: expect busy=0 next cycle and no done pulse; a subsequent NTT completes normally in 285 cycles.
